// File: rtl/tri_raster_scan_pkg.sv
// Shared types for the bounding-box rasterizer: vertex/triangle input,
// fragment output record, FSM states and small min/max helpers.
package tri_raster_scan_pkg;

  localparam int COORD_W = 12;
  localparam int EDGE_W  = 2 * COORD_W + 2;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] z;
  } vertex_t;

  typedef struct packed {
    vertex_t p;
    vertex_t q;
    vertex_t r;
  } Triangle3D;

  // w[2] = w_qr, w[1] = w_rp, w[0] = w_pq
  typedef struct packed {
    logic [COORD_W-1:0]       x;
    logic [COORD_W-1:0]       y;
    logic [2:0][EDGE_W-1:0]   w;
    logic [EDGE_W-1:0]        area;
  } frag_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SCAN  = 2'd2
  } raster_state_t;

  function automatic logic signed [COORD_W-1:0] min3(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b,
    input logic signed [COORD_W-1:0] c
  );
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [COORD_W-1:0] max3(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b,
    input logic signed [COORD_W-1:0] c
  );
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tri_raster_scan_if.sv
// Triangle-in / fragment-out handshake bundle of the rasterizer.
interface tri_raster_scan_if;
  import tri_raster_scan_pkg::*;

  logic                   tri_valid;
  logic                   tri_ready;
  Triangle3D              tri_in;
  logic                   frag_valid;
  logic                   frag_ready;
  logic [COORD_W-1:0]     frag_x;
  logic [COORD_W-1:0]     frag_y;
  logic [2:0][EDGE_W-1:0] frag_w;
  logic [EDGE_W-1:0]      frag_area;
  logic                   tri_done;
  logic                   busy;

  modport master (
    output tri_valid, tri_in, frag_ready,
    input  tri_ready, frag_valid, frag_x, frag_y, frag_w, frag_area, tri_done, busy
  );

  modport slave (
    input  tri_valid, tri_in, frag_ready,
    output tri_ready, frag_valid, frag_x, frag_y, frag_w, frag_area, tri_done, busy
  );

endinterface

// File: rtl/tri_raster_scan_edge_setup.sv
// Edge function E_ab(x,y) = (x-ax)*(by-ay) - (y-ay)*(bx-ax): step coefficients
// and value at corner (x0,y0). Purely combinational; the only multipliers.
module tri_raster_scan_edge_setup
  import tri_raster_scan_pkg::*;
(
  input  logic signed [COORD_W-1:0] ax,
  input  logic signed [COORD_W-1:0] ay,
  input  logic signed [COORD_W-1:0] bx,
  input  logic signed [COORD_W-1:0] by,
  input  logic signed [COORD_W-1:0] x0,
  input  logic signed [COORD_W-1:0] y0,
  output logic signed [EDGE_W-1:0]  a_coef,
  output logic signed [EDGE_W-1:0]  b_coef,
  output logic signed [EDGE_W-1:0]  e0
);

  logic signed [COORD_W:0] dx_ab, dy_ab, dx_0, dy_0;

  assign dx_ab = (COORD_W+1)'(bx) - (COORD_W+1)'(ax);
  assign dy_ab = (COORD_W+1)'(by) - (COORD_W+1)'(ay);
  assign dx_0  = (COORD_W+1)'(x0) - (COORD_W+1)'(ax);
  assign dy_0  = (COORD_W+1)'(y0) - (COORD_W+1)'(ay);

  assign a_coef = EDGE_W'(dy_ab);
  assign b_coef = -EDGE_W'(dx_ab);
  assign e0     = EDGE_W'(dx_0) * EDGE_W'(dy_ab) - EDGE_W'(dy_0) * EDGE_W'(dx_ab);

endmodule

// File: rtl/tri_raster_scan.sv
// Bounding-box rasterizer: edge setup once per triangle, then a row-major
// walk of the screen-clipped box emitting one covered pixel per cycle.
module tri_raster_scan
  import tri_raster_scan_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  tri_raster_scan_if.slave bus
);

  localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

  raster_state_t state_q, state_d;

  logic signed [COORD_W-1:0] vx_q [3], vx_d [3];
  logic signed [COORD_W-1:0] vy_q [3], vy_d [3];
  logic signed [EDGE_W-1:0]  a_q [3], a_d [3];
  logic signed [EDGE_W-1:0]  b_q [3], b_d [3];
  logic signed [EDGE_W-1:0]  e_q [3], e_d [3];
  logic signed [EDGE_W-1:0]  erow_q [3], erow_d [3];
  logic signed [EDGE_W-1:0]  a_set [3], b_set [3], e_set [3];
  logic signed [EDGE_W-1:0]  area_q, area_d, area_raw;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;

  logic  eval_done_q, eval_done_d;
  logic  frag_valid_q, frag_valid_d;
  logic  tri_done_q, tri_done_d;
  frag_t frag_q, frag_d;

  logic signed [COORD_W-1:0] raw_xmin, raw_xmax, raw_ymin, raw_ymax;
  logic signed [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic bbox_empty, flip, tri_ready, stall, covered, last_pixel;
  logic unused_z;

  assign raw_xmin = min3(vx_q[0], vx_q[1], vx_q[2]);
  assign raw_xmax = max3(vx_q[0], vx_q[1], vx_q[2]);
  assign raw_ymin = min3(vy_q[0], vy_q[1], vy_q[2]);
  assign raw_ymax = max3(vy_q[0], vy_q[1], vy_q[2]);
  assign bb_xmin  = (raw_xmin < 0) ? '0 : raw_xmin;
  assign bb_ymin  = (raw_ymin < 0) ? '0 : raw_ymin;
  assign bb_xmax  = (raw_xmax > X_LIM) ? X_LIM : raw_xmax;
  assign bb_ymax  = (raw_ymax > Y_LIM) ? Y_LIM : raw_ymax;
  assign bbox_empty = (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax);

  // Edge gi runs from vertex gi to vertex gi+1: pq, qr, rp.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      tri_raster_scan_edge_setup u_edge (
        .ax     (vx_q[gi]),
        .ay     (vy_q[gi]),
        .bx     (vx_q[(gi + 1) % 3]),
        .by     (vy_q[(gi + 1) % 3]),
        .x0     (bb_xmin),
        .y0     (bb_ymin),
        .a_coef (a_set[gi]),
        .b_coef (b_set[gi]),
        .e0     (e_set[gi])
      );
    end
  endgenerate

  // The three edge functions always sum to the doubled signed area.
  assign area_raw = e_set[0] + e_set[1] + e_set[2];
  assign flip     = area_raw[EDGE_W-1];

  assign tri_ready  = (state_q == ST_IDLE) && !tri_done_q;
  assign stall      = frag_valid_q && !bus.frag_ready;
  assign covered    = !e_q[0][EDGE_W-1] && !e_q[1][EDGE_W-1] && !e_q[2][EDGE_W-1];
  assign last_pixel = (x_q == xmax_q) && (y_q == ymax_q);
  assign unused_z   = ^{bus.tri_in.p.z, bus.tri_in.q.z, bus.tri_in.r.z};

  always_comb begin
    state_d      = state_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    a_d          = a_q;
    b_d          = b_q;
    e_d          = e_q;
    erow_d       = erow_q;
    area_d       = area_q;
    x_d          = x_q;
    y_d          = y_q;
    xmin_d       = xmin_q;
    xmax_d       = xmax_q;
    ymax_d       = ymax_q;
    eval_done_d  = eval_done_q;
    frag_valid_d = frag_valid_q;
    frag_d       = frag_q;
    tri_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.tri_valid && tri_ready) begin
          vx_d[0] = bus.tri_in.p.x;
          vy_d[0] = bus.tri_in.p.y;
          vx_d[1] = bus.tri_in.q.x;
          vy_d[1] = bus.tri_in.q.y;
          vx_d[2] = bus.tri_in.r.x;
          vy_d[2] = bus.tri_in.r.y;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if ((area_raw == '0) || bbox_empty) begin
          tri_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          for (int i = 0; i < 3; i++) begin
            a_d[i]    = flip ? -a_set[i] : a_set[i];
            b_d[i]    = flip ? -b_set[i] : b_set[i];
            e_d[i]    = flip ? -e_set[i] : e_set[i];
            erow_d[i] = flip ? -e_set[i] : e_set[i];
          end
          area_d      = flip ? -area_raw : area_raw;
          x_d         = bb_xmin;
          y_d         = bb_ymin;
          xmin_d      = bb_xmin;
          xmax_d      = bb_xmax;
          ymax_d      = bb_ymax;
          eval_done_d = 1'b0;
          state_d     = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (!stall) begin
          if (eval_done_q) begin
            frag_valid_d = 1'b0;
            tri_done_d   = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            frag_valid_d = covered;
            if (covered) begin
              frag_d.x    = x_q;
              frag_d.y    = y_q;
              frag_d.w    = {e_q[1], e_q[2], e_q[0]};
              frag_d.area = area_q;
            end
            if (x_q < xmax_q) begin
              x_d = x_q + COORD_W'(1);
              for (int i = 0; i < 3; i++) e_d[i] = e_q[i] + a_q[i];
            end else begin
              x_d = xmin_q;
              y_d = y_q + COORD_W'(1);
              for (int i = 0; i < 3; i++) begin
                erow_d[i] = erow_q[i] + b_q[i];
                e_d[i]    = erow_q[i] + b_q[i];
              end
            end
            eval_done_d = last_pixel;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vx_q         <= '{default: '0};
      vy_q         <= '{default: '0};
      a_q          <= '{default: '0};
      b_q          <= '{default: '0};
      e_q          <= '{default: '0};
      erow_q       <= '{default: '0};
      area_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymax_q       <= '0;
      eval_done_q  <= 1'b0;
      frag_valid_q <= 1'b0;
      frag_q       <= '0;
      tri_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      a_q          <= a_d;
      b_q          <= b_d;
      e_q          <= e_d;
      erow_q       <= erow_d;
      area_q       <= area_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymax_q       <= ymax_d;
      eval_done_q  <= eval_done_d;
      frag_valid_q <= frag_valid_d;
      frag_q       <= frag_d;
      tri_done_q   <= tri_done_d;
    end
  end

  assign bus.tri_ready  = tri_ready;
  assign bus.frag_valid = frag_valid_q;
  assign bus.frag_x     = frag_q.x;
  assign bus.frag_y     = frag_q.y;
  assign bus.frag_w     = frag_q.w;
  assign bus.frag_area  = frag_q.area;
  assign bus.tri_done   = tri_done_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
